// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM encoding,
// line levels and a sizing helper for the counters.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_register_piso.sv
// Parallel-in, serial-out shift register built from enabled D flip-flops.
// Bit 0 is the serial output; shifting moves the word toward bit 0.
module shift_register_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d_par,
  output logic             q_ser
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  always_comb begin
    // NOTE: default first so every path assigns d; otherwise a latch is inferred.
    d = q;
    if (load)       d = d_par;
    else if (shift) d = q >> 1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all flops sample pre-edge values, matching hardware.
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

  assign q_ser = q[0];

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, WIDTH data bits LSB first, stop bit, each
// held BIT_CYCLES enabled clocks. All outputs come straight from flops.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int TW = clog2_min1(BIT_CYCLES);
  localparam int IW = clog2_min1(WIDTH);

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [IW-1:0]   bit_idx, bit_idx_n;
  logic            tx_n, ready_n, busy_n, done_n;
  logic            sr_load, sr_shift, sr_q;
  logic            wrap;

  shift_register_piso #(.WIDTH(WIDTH)) u_sr (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .load  (sr_load),
    .shift (sr_shift),
    .d_par (data_in),
    .q_ser (sr_q)
  );

  assign wrap = (timer == TW'(BIT_CYCLES - 1));

  // The register is shifted at the start of each data bit rather than the
  // end, so the flopped tx can take the new bit 0 on the same edge.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    tx_n      = tx;
    ready_n   = ready;
    busy_n    = busy;
    done_n    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (load && ready) begin
            state_n = START;
            timer_n = '0;
            tx_n    = START_BIT;
            ready_n = 1'b0;
            busy_n  = 1'b1;
            sr_load = 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            state_n   = DATA;
            timer_n   = '0;
            bit_idx_n = '0;
            tx_n      = sr_q;
            sr_shift  = 1'b1;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        DATA: begin
          if (wrap) begin
            timer_n = '0;
            if (bit_idx == IW'(WIDTH - 1)) begin
              state_n = STOP;
              tx_n    = STOP_BIT;
            end else begin
              bit_idx_n = bit_idx + IW'(1);
              tx_n      = sr_q;
              sr_shift  = 1'b1;
            end
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        STOP: begin
          if (wrap) begin
            state_n = IDLE;
            timer_n = '0;
            tx_n    = TX_IDLE_LEVEL;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      tx      <= TX_IDLE_LEVEL;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
      ready   <= ready_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a queue-of-line-levels model compared
// every cycle, plus literal expectations for the directed frames.
module tb_serial_tx;

  localparam int W = 8;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         reset, en, load;
  logic [W-1:0] data_in;
  logic         ready, tx, busy, done;

  logic         en2, load2;
  logic [0:0]   data2;
  logic         ready2, tx2, busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic m_tx, m_ready, m_busy, m_done;
  logic q_line[$];
  logic cap[$];

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(W), .BIT_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .load(load),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  serial_tx #(.WIDTH(1), .BIT_CYCLES(1)) dut_small (
    .clk(clk), .reset(reset), .en(en2), .data_in(data2), .load(load2),
    .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a frame is the full list of line levels, one per enabled cycle.
  always @(posedge clk) begin : model
    logic t_tx, t_ready, t_busy, t_done;
    t_tx = m_tx; t_ready = m_ready; t_busy = m_busy; t_done = 1'b0;
    if (reset) begin
      q_line.delete();
      t_tx = 1'b1; t_ready = 1'b1; t_busy = 1'b0;
    end else if (en) begin
      if (t_busy) begin
        if (q_line.size() > 0) t_tx = q_line.pop_front();
        else begin
          t_busy = 1'b0; t_ready = 1'b1; t_tx = 1'b1; t_done = 1'b1;
        end
      end else if (load) begin
        q_line.delete();
        for (int p = 0; p < W + 2; p++)
          for (int c = 0; c < B; c++)
            q_line.push_back((p == 0) ? 1'b0 : (p == W + 1) ? 1'b1 : data_in[p-1]);
        t_tx = q_line.pop_front();
        t_busy = 1'b1; t_ready = 1'b0;
      end
    end
    m_tx <= t_tx; m_ready <= t_ready; m_busy <= t_busy; m_done <= t_done;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx", tx, m_tx);
      check("model_ready", ready, m_ready);
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
    end
  end

  // Sends one word, optionally injecting a stray load or an enable stall;
  // returns the number of clocks from the accepting edge to done.
  task automatic run_frame(input logic [W-1:0] d, input int inj_at,
                           input int stall_at, input int stall_len, output int lat);
    data_in = d; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    cap.delete();
    lat = 0;
    while (!done && lat < 200) begin
      cap.push_back(tx);
      load = (lat == inj_at);
      if (lat == inj_at) data_in = 8'hFF;
      en = !(lat >= stall_at && lat < stall_at + stall_len);
      tick();
      lat++;
    end
    load = 1'b0; en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int a5_line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    reset = 1'b1; en = 1'b1; load = 1'b0; data_in = '0;
    en2 = 1'b1; load2 = 1'b0; data2 = '0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_tx", tx, 1); check("rst_ready", ready, 1);
    check("rst_busy", busy, 0); check("rst_done", done, 0);

    // WIDTH=1, BIT_CYCLES=1: line 0,1,1 then done.
    data2 = 1'b1; load2 = 1'b1;
    tick();
    load2 = 1'b0;
    check("small_start", tx2, 0); check("small_busy", busy2, 1);
    tick(); check("small_data", tx2, 1);
    tick(); check("small_stop", tx2, 1); check("small_nodone", done2, 0);
    tick(); check("small_done", done2, 1); check("small_ready", ready2, 1);
    check("small_idle", busy2, 0);
    tick(); check("small_done_fall", done2, 0);

    // Single 8'hA5 frame.
    run_frame(8'hA5, -1, -1, 0, lat);
    check("a5_latency", lat, 40);
    check("a5_len", cap.size(), 40);
    for (int k = 0; k < 40 && k < cap.size(); k++)
      check("a5_line", cap[k], a5_line[k/4]);
    check("a5_done", done, 1);
    tick(); check("a5_done_fall", done, 0);

    // Stray load during a frame is ignored.
    run_frame(8'h00, 10, -1, 0, lat);
    check("ign_latency", lat, 40);
    for (int k = 4; k < 36 && k < cap.size(); k++)
      check("ign_data_zero", cap[k], 0);
    tick();

    // Enable stall of 7 cycles inside DATA.
    run_frame(8'h5A, -1, 15, 7, lat);
    check("stall_latency", lat, 47);
    tick();

    // Back-to-back with load held high.
    data_in = 8'h3C; load = 1'b1;
    tick();
    data_in = 8'hC3;
    lat = 0;
    while (!done && lat < 200) begin tick(); lat++; end
    check("b2b_first_latency", lat, 40);
    check("b2b_stop_level", tx, 1);
    tick();
    check("b2b_start_level", tx, 0); check("b2b_busy", busy, 1);
    load = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin tick(); lat++; end
    check("b2b_second_latency", lat, 40);
    tick();

    // Reset in the middle of a frame.
    data_in = 8'hFF; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (12) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("midrst_tx", tx, 1); check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0); check("midrst_done", done, 0);
    repeat (5) tick();
    check("midrst_stay_idle", busy, 0); check("midrst_stay_tx", tx, 1);

    // Random traffic against the model.
    repeat (3000) begin
      reset   = ($urandom_range(0, 499) == 0);
      en      = ($urandom_range(0, 7) != 0);
      load    = ($urandom_range(0, 3) == 0);
      data_in = W'($urandom);
      tick();
    end
    reset = 1'b0; en = 1'b1; load = 1'b0;
    repeat (60) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
